// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: FSM encodings,
// default operand widths and the iteration counter width.
package seq_divider_pkg;

   localparam int N_BITS_DEF = 8;
   localparam int D_BITS_DEF = 4;
   localparam int CNT_W_DEF  = $clog2(N_BITS_DEF + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Ripple-borrow subtractor used for the per-iteration trial subtraction.
// borrow is the true borrow-out of the chain (a < b), not the diff MSB.
module div_trial_sub #(
   parameter int W = 5
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   logic chain;

   // Full-subtractor cells rippling the borrow from LSB to MSB
   always_comb begin
      chain = 1'b0;
      diff  = '0;
      for (int i = 0; i < W; i++) begin
         diff[i] = a[i] ^ b[i] ^ chain;
         chain   = (~a[i] & b[i]) | (~a[i] & chain) | (b[i] & chain);
      end
      borrow = chain;
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock.
// Optional macro SEQ_DIVIDER_DIVZERO_TRAP_EN: a zero divisor skips the
// iterations, finishes in one cycle and raises DivZero. Without it DivZero
// is tied low and a zero divisor simply runs the normal iterations.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF,
   parameter int D_BITS = D_BITS_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [N_BITS-1:0] Dividend,
   input  logic [D_BITS-1:0] Divisor,
   output logic [N_BITS-1:0] Quotient,
   output logic [D_BITS-1:0] Remainder,
   output logic              Busy,
   output logic              Done,
   output logic              DivZero
);

   localparam int            CW   = $clog2(N_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

   state_t              state, state_nxt;
   logic [N_BITS-1:0]   q_reg, q_next;
   logic [D_BITS-1:0]   d_reg, p_reg, p_next;
   logic [CW-1:0]       cnt;
   logic [D_BITS:0]     trial_a, trial_b, trial_diff;
   logic                trial_borrow;
   logic                trial_msb_unused;
   logic                accept, last_iter, div_zero_req;

`ifdef SEQ_DIVIDER_DIVZERO_TRAP_EN
   assign div_zero_req = (Divisor == '0);
`else
   assign div_zero_req = 1'b0;
`endif

   // Shift the next dividend bit into the partial remainder and try D
   assign trial_a          = {p_reg, q_reg[N_BITS-1]};
   assign trial_b          = {1'b0, d_reg};
   assign trial_msb_unused = trial_diff[D_BITS];

   div_trial_sub #(.W(D_BITS + 1)) u_trial (
      .a      (trial_a),
      .b      (trial_b),
      .diff   (trial_diff),
      .borrow (trial_borrow)
   );

   assign q_next    = {q_reg[N_BITS-2:0], ~trial_borrow};
   assign p_next    = trial_borrow ? trial_a[D_BITS-1:0] : trial_diff[D_BITS-1:0];
   assign last_iter = (cnt == LAST);

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and Start acceptance
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = div_zero_req ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (last_iter) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, iteration datapath and result registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         q_reg     <= '0;
         d_reg     <= '0;
         p_reg     <= '0;
         cnt       <= '0;
         Quotient  <= '0;
         Remainder <= '0;
      end else if (accept) begin
         q_reg <= Dividend;
         d_reg <= Divisor;
         p_reg <= '0;
         cnt   <= '0;
         if (div_zero_req) begin
            Quotient  <= '1;
            Remainder <= Dividend[D_BITS-1:0];
         end
      end else if (state == S_RUN) begin
         q_reg <= q_next;
         p_reg <= p_next;
         cnt   <= cnt + 1'b1;
         if (last_iter) begin
            Quotient  <= q_next;
            Remainder <= p_next;
         end
      end
   end

`ifdef SEQ_DIVIDER_DIVZERO_TRAP_EN
   // Divide-by-zero flag follows the most recently accepted operands
   always_ff @(posedge Clock) begin
      if (Reset)       DivZero <= 1'b0;
      else if (accept) DivZero <= div_zero_req;
   end
`else
   assign DivZero = 1'b0;
`endif

   assign Busy = (state == S_RUN);
   assign Done = (state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases with literal expectations plus a
// randomized phase checked every cycle against a behavioural model.
module tb_seq_divider;

   logic       Clock = 1'b0;
   logic       Reset, Start;
   logic [7:0] Dividend, Quotient;
   logic [3:0] Divisor, Remainder;
   logic       Busy, Done, DivZero;

`ifdef SEQ_DIVIDER_DIVZERO_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   seq_divider dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .Busy      (Busy),
      .Done      (Done),
      .DivZero   (DivZero)
   );

   always #5 Clock = ~Clock;

   // Behavioural model: a division takes 8 cycles (or finishes at once for
   // a trapped zero divisor) and yields a/b, a%b, with b==0 -> FF, a[3:0].
   bit         m_run, m_done, m_dz;
   int         m_left, m_a, m_b;
   logic [7:0] m_q;
   logic [3:0] m_r;

   always @(posedge Clock) begin
      if (Reset) begin
         m_run = 0; m_done = 0; m_dz = 0; m_left = 0; m_q = 0; m_r = 0;
      end else if (!m_run && Start) begin
         m_a = Dividend; m_b = Divisor; m_done = 0; m_dz = 0;
         if (TRAP && m_b == 0) begin
            m_done = 1; m_dz = 1; m_q = 8'hFF; m_r = Dividend[3:0];
         end else begin
            m_run = 1; m_left = 8;
         end
      end else if (m_run) begin
         m_left--;
         if (m_left == 0) begin
            m_run  = 0;
            m_done = 1;
            m_q    = (m_b == 0) ? 8'hFF : 8'(m_a / m_b);
            m_r    = (m_b == 0) ? 4'(m_a % 16) : 4'(m_a % m_b);
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge Clock) begin
      if (chk_en) begin
         n_cmp++;
         if ({Busy, Done, DivZero, Quotient, Remainder} !== {m_run, m_done, m_dz, m_q, m_r}) begin
            n_bad++;
            $display("FAIL model t=%0t: got busy=%b done=%b dz=%b q=%0d r=%0d, expected busy=%b done=%b dz=%b q=%0d r=%0d",
                     $time, Busy, Done, DivZero, Quotient, Remainder, m_run, m_done, m_dz, m_q, m_r);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Launch one division and wait (bounded) for Done
   task automatic do_div(input logic [7:0] a, input logic [3:0] b, input bit hold,
                         input logic [7:0] eq, input logic [3:0] er, input int elat,
                         input string nm);
      int lat;
      Dividend = a; Divisor = b; Start = 1'b1;
      @(negedge Clock);
      if (!hold) Start = 1'b0;
      if (elat != 0) chk({nm, "_done_drop"}, Done, 0);
      lat = 0;
      while (!Done && lat < 40) begin
         @(negedge Clock);
         lat++;
      end
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_quot"}, Quotient, eq);
      chk({nm, "_rem"}, Remainder, er);
   endtask

   initial begin
      int lat;
      Reset = 1'b1; Start = 1'b0; Dividend = '0; Divisor = '0;
      @(negedge Clock);
      @(negedge Clock);
      chk_en = 1'b1;
      chk("reset_busy", Busy, 0);
      chk("reset_done", Done, 0);
      chk("reset_quot", Quotient, 0);
      chk("reset_dz", DivZero, 0);
      Reset = 1'b0;
      @(negedge Clock);

      do_div(8'd200, 4'd7, 0, 8'd28, 4'd4, 8, "d200_7");
      chk("model_pin_q", m_q, 28);
      chk("model_pin_r", m_r, 4);

      // Reset in the middle of a run clears everything
      Dividend = 8'd200; Divisor = 4'd7; Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (3) @(negedge Clock);
      chk("midrun_busy_before", Busy, 1);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      chk("midrun_busy", Busy, 0);
      chk("midrun_done", Done, 0);
      chk("midrun_quot", Quotient, 0);
      chk("midrun_rem", Remainder, 0);
      @(negedge Clock);

      do_div(8'd255, 4'd1, 0, 8'd255, 4'd0, 8, "d255_1");
      do_div(8'd0, 4'd5, 0, 8'd0, 4'd0, 8, "d0_5");

      // Start pulsed during RUN must be ignored
      Dividend = 8'd100; Divisor = 4'd10; Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (2) @(negedge Clock);
      Dividend = 8'd50; Divisor = 4'd3; Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      lat = 3;
      while (!Done && lat < 40) begin
         @(negedge Clock);
         lat++;
      end
      chk("ignore_latency", lat, 8);
      chk("ignore_quot", Quotient, 10);
      chk("ignore_rem", Remainder, 0);

      // Start held high: back-to-back operations
      do_div(8'd100, 4'd10, 1, 8'd10, 4'd0, 8, "held1");
      do_div(8'd15, 4'd15, 1, 8'd1, 4'd0, 8, "held2");
      Start = 1'b0;
      @(negedge Clock);

      // Zero divisor
      do_div(8'hA7, 4'd0, 0, 8'hFF, 4'h7, TRAP ? 0 : 8, "divzero");
      chk("divzero_flag", DivZero, TRAP ? 1 : 0);
      repeat (3) @(negedge Clock);
      chk("divzero_hold_done", Done, 1);

      // Randomized phase, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         Start    = ($urandom_range(0, 3) == 0);
         Dividend = 8'($urandom);
         Divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
         Reset    = ($urandom_range(0, 299) == 0);
         @(negedge Clock);
      end
      Reset = 1'b0; Start = 1'b0;
      repeat (12) @(negedge Clock);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
